gcd_stein: RTL and testbench

GCD_STEIN -- requirements
Module: gcd_stein

---
 rtl/gcd_stein.sv | 146 ++++++++++++++
 tb/tb_gcd_stein.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: shift/subtract only, with a per-computation busy-cycle budget.
// Reports the result, a coprime flag, a timeout flag and the busy-cycle count.
module gcd_stein #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 4 * WIDTH + 8,
    localparam int unsigned CW        = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             coprime_o,
    output logic             timeout_o,
    output logic [CW-1:0]    cycles_o
);

    localparam int unsigned KW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StCheck, StStrip, StReduce, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
    logic             coprime_q, coprime_d, timeout_q, timeout_d;
    logic             budget_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            coprime_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            coprime_q <= coprime_d;
            timeout_q <= timeout_d;
        end
    end

    // Budget check uses the count before this cycle's increment.
    assign budget_hit = (cnt_q >= CW'(MAX_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        coprime_d = coprime_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d       = a_i;
                    b_d       = b_i;
                    k_d       = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    coprime_d = 1'b0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                cnt_d = cnt_q + CW'(1);
                if (a_q == '0 || b_q == '0) begin
                    result_d = a_q | b_q;
                    state_d  = StDone;
                end else begin
                    state_d = StStrip;
                end
            end
            StStrip: begin
                cnt_d = cnt_q + CW'(1);
                if (budget_hit) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else begin
                    state_d = StReduce;
                end
            end
            StReduce: begin
                cnt_d = cnt_q + CW'(1);
                if (a_q[0] && b_q[0] && a_q == b_q) begin
                    // a_q carries no factor of two stripped into k, so this cannot overflow.
                    result_d = a_q << k_q;
                    state_d  = StDone;
                end else if (budget_hit) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d == StDone && state_q != StDone) begin
            cycles_d  = cnt_d;
            coprime_d = (result_d == WIDTH'(1)) && !timeout_d;
        end
    end

    always_comb begin
        busy_o    = (state_q == StCheck) || (state_q == StStrip) || (state_q == StReduce);
        valid_o   = (state_q == StDone);
        result_o  = result_q;
        coprime_o = coprime_q;
        timeout_o = timeout_q;
        cycles_o  = cycles_q;
    end

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: directed vector table, corner sequences and random operands
// against a Euclid-based reference.
module tb_gcd_stein;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;

    logic        busy0, valid0, cop0, to0;
    logic [31:0] res0;
    logic [7:0]  cyc0;
    logic        busy1, valid1, cop1, to1;
    logic [7:0]  res1;
    logic [5:0]  cyc1;
    logic        busy2, valid2, cop2, to2;
    logic [7:0]  res2;
    logic [2:0]  cyc2;

    int          sel;
    logic        s_busy, s_valid, s_cop, s_to;
    logic [31:0] s_res, s_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gcd_stein u_main (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy0), .valid_o(valid0), .result_o(res0), .coprime_o(cop0),
        .timeout_o(to0), .cycles_o(cyc0)
    );

    gcd_stein #(.WIDTH(8)) u_w8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a[7:0]), .b_i(b[7:0]),
        .busy_o(busy1), .valid_o(valid1), .result_o(res1), .coprime_o(cop1),
        .timeout_o(to1), .cycles_o(cyc1)
    );

    gcd_stein #(.WIDTH(8), .MAX_CYCLES(5)) u_to (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a[7:0]), .b_i(b[7:0]),
        .busy_o(busy2), .valid_o(valid2), .result_o(res2), .coprime_o(cop2),
        .timeout_o(to2), .cycles_o(cyc2)
    );

    always_comb begin
        s_busy = busy0; s_valid = valid0; s_cop = cop0; s_to = to0;
        s_res = res0; s_cyc = {24'd0, cyc0};
        if (sel == 1) begin
            s_busy = busy1; s_valid = valid1; s_cop = cop1; s_to = to1;
            s_res = {24'd0, res1}; s_cyc = {26'd0, cyc1};
        end else if (sel == 2) begin
            s_busy = busy2; s_valid = valid2; s_cop = cop2; s_to = to2;
            s_res = {24'd0, res2}; s_cyc = {29'd0, cyc2};
        end
    end

    function automatic logic [31:0] ref_gcd(logic [31:0] x, logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Busy-cycle count: one check, k strip cycles plus the exit, then one cycle per reduction step.
    function automatic int ref_cycles(logic [31:0] x, logic [31:0] y);
        int n;
        if (x == 0 || y == 0) return 1;
        n = 1;
        while (x[0] == 1'b0 && y[0] == 1'b0) begin
            x = x >> 1;
            y = y >> 1;
            n++;
        end
        n++;
        forever begin
            n++;
            if (x[0] == 1'b0) x = x >> 1;
            else if (y[0] == 1'b0) y = y >> 1;
            else if (x == y) break;
            else if (x > y) x = x - y;
            else y = y - x;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1 && !busy2 && !valid0 && !valid1 && !valid2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_wait", 32'd0, 32'd1);
    endtask

    // Start on the next edge; count busy cycles until valid on the selected DUT.
    task automatic run(input int s, input logic [31:0] x, input logic [31:0] y, input bit hold,
                       output int nbusy);
        bit got = 0;
        wait_idle();
        sel   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 400; i++) begin
            if (s_valid) begin
                got = 1;
                break;
            end
            if (s_busy) nbusy++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) chk("valid_wait", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          cyc;
        bit          cop;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          nb;
        logic [31:0] x, y, g, held;
        tbl[0] = '{a: 32'd48, b: 32'd18, res: 32'd6, cyc: 9,  cop: 1'b0};
        tbl[1] = '{a: 32'd0,  b: 32'd0,  res: 32'd0, cyc: 1,  cop: 1'b0};
        tbl[2] = '{a: 32'd0,  b: 32'd7,  res: 32'd7, cyc: 1,  cop: 1'b0};
        tbl[3] = '{a: 32'd7,  b: 32'd0,  res: 32'd7, cyc: 1,  cop: 1'b0};
        tbl[4] = '{a: 32'd17, b: 32'd13, res: 32'd1, cyc: 11, cop: 1'b1};
        tbl[5] = '{a: 32'd1,  b: 32'd1,  res: 32'd1, cyc: 3,  cop: 1'b1};

        sel = 0; start = 1'b0; a = '0; b = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_result", s_res, 32'd0);
        chk("rst_cycles", s_cyc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(0, tbl[i].a, tbl[i].b, 1'b0, nb);
            chk($sformatf("tbl%0d_result", i), s_res, tbl[i].res);
            chk($sformatf("tbl%0d_cycles", i), s_cyc, tbl[i].cyc);
            chk($sformatf("tbl%0d_busy", i), nb, tbl[i].cyc);
            chk($sformatf("tbl%0d_coprime", i), {31'd0, s_cop}, {31'd0, tbl[i].cop});
            chk($sformatf("tbl%0d_timeout", i), {31'd0, s_to}, 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_strobe", i), {31'd0, s_valid}, 32'd0);
            chk($sformatf("tbl%0d_hold", i), s_res, tbl[i].res);
        end

        // Start held high through busy must not re-latch.
        run(0, 32'd17, 32'd13, 1'b1, nb);
        chk("hold_result", s_res, 32'd1);
        chk("hold_coprime", {31'd0, s_cop}, 32'd1);
        chk("hold_cycles", s_cyc, 32'd11);

        // Asynchronous reset in the middle of reducing (48,18).
        run(0, 32'd1, 32'd1, 1'b0, nb);
        wait_idle();
        sel = 0; a = 32'd48; b = 32'd18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, s_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, s_busy}, 32'd0);
        chk("arst_valid", {31'd0, s_valid}, 32'd0);
        chk("arst_result", s_res, 32'd0);
        chk("arst_coprime", {31'd0, s_cop}, 32'd0);
        chk("arst_cycles", s_cyc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 32'd12, 32'd8, 1'b0, nb);
        chk("post_rst_result", s_res, 32'd4);
        chk("post_rst_timeout", {31'd0, s_to}, 32'd0);

        // Narrow instance boundaries.
        run(1, 32'd255, 32'd255, 1'b0, nb);
        chk("w8_255_result", s_res, 32'd255);
        chk("w8_255_timeout", {31'd0, s_to}, 32'd0);
        run(1, 32'd128, 32'd64, 1'b0, nb);
        chk("w8_128_result", s_res, 32'd64);
        chk("w8_128_timeout", {31'd0, s_to}, 32'd0);
        chk("w8_128_cycles", s_cyc, ref_cycles(32'd128, 32'd64));
        run(1, 32'd254, 32'd1, 1'b0, nb);
        chk("w8_254_result", s_res, 32'd1);
        chk("w8_254_coprime", {31'd0, s_cop}, 32'd1);
        chk("w8_254_timeout", {31'd0, s_to}, 32'd0);

        // Tight budget forces a timeout on (48,18).
        run(2, 32'd48, 32'd18, 1'b0, nb);
        chk("to_busy", nb, 32'd5);
        chk("to_timeout", {31'd0, s_to}, 32'd1);
        chk("to_result", s_res, 32'd0);
        chk("to_coprime", {31'd0, s_cop}, 32'd0);
        chk("to_cycles", s_cyc, 32'd5);

        for (int i = 0; i < 40; i++) begin
            int sh;
            sh = $urandom_range(0, 6);
            x = ($urandom >> $urandom_range(0, 28)) << sh;
            y = ($urandom >> $urandom_range(0, 28)) << sh;
            if (i % 8 == 3) y = x;
            if (i % 8 == 5) x = 32'hFFFF_FFFF;
            g = ref_gcd(x, y);
            run(0, x, y, 1'b0, nb);
            chk($sformatf("rnd%0d_result(%0d,%0d)", i, x, y), s_res, g);
            chk($sformatf("rnd%0d_cycles", i), s_cyc, ref_cycles(x, y));
            chk($sformatf("rnd%0d_busy", i), nb, ref_cycles(x, y));
            chk($sformatf("rnd%0d_coprime", i), {31'd0, s_cop}, {31'd0, g == 32'd1});
            chk($sformatf("rnd%0d_timeout", i), {31'd0, s_to}, 32'd0);
            held = s_res;
            @(negedge clk);
            chk($sformatf("rnd%0d_hold", i), s_res, held);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
